mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter_if.sv | 40 ++++
 rtl/mul_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter_if
// Purpose  : Requester and shared-multiplier signals of mul_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 done0;
    logic                 done1;
    logic [2*WIDTH-1:0]   result;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_out;
    logic                 err;

    // Requesters plus the multiplier controller.
    modport master (
        output req0, req1, a0, b0, a1, b1, mul_done, mul_out,
        input  gnt0, gnt1, done0, done1, result, mul_start, mul_a, mul_b, err
    );

    // The arbiter.
    modport slave (
        input  req0, req1, a0, b0, a1, b1, mul_done, mul_out,
        output gnt0, gnt1, done0, done1, result, mul_start, mul_a, mul_b, err
    );
endinterface
`default_nettype wire

// File: rtl/mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_arbiter
// Purpose  : Round-robin arbiter sharing one multiplier between two requesters.
//            Optional WAIT timeout abort enabled by macro ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mul_arbiter_if.slave bus
);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    if (TIMEOUT < 1) begin : g_timeout_range
        $error("mul_arbiter: TIMEOUT must be at least 1");
    end

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic               r_owner;     // 1: requester 1 owns the multiplier
    logic               r_last;      // 1: requester 1 was served last
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [2*WIDTH-1:0] r_result;
    logic               w_any_req;
    logic               w_pick;
    logic               w_expire;

    assign w_any_req = bus.req0 | bus.req1;
    // Contention goes to whoever was not served last; otherwise the sole requester.
    assign w_pick    = (bus.req0 & bus.req1) ? ~r_last : ~bus.req0;

`ifdef ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_tmo;

    assign w_expire = (r_wait_cnt == c_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_tmo      <= 1'b0;
        end else if (r_state == c_ISSUE) begin
            r_wait_cnt <= '0;
            r_tmo      <= 1'b0;
        end else if (r_state == c_WAIT && !bus.mul_done) begin
            if (w_expire) begin
                r_tmo <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_any_req) w_next_state = c_ISSUE;
            c_ISSUE: w_next_state = c_WAIT;
            c_WAIT:  if (bus.mul_done || w_expire) w_next_state = c_RESP;
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_IDLE: if (w_any_req) begin
                    r_owner <= w_pick;
                    r_mul_a <= w_pick ? bus.a1 : bus.a0;
                    r_mul_b <= w_pick ? bus.b1 : bus.b0;
                end
                c_WAIT: if (bus.mul_done) r_result <= bus.mul_out;
                c_RESP: r_last <= r_owner;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.gnt0      = 1'b0;
        bus.gnt1      = 1'b0;
        bus.done0     = 1'b0;
        bus.done1     = 1'b0;
        bus.mul_start = 1'b0;
        bus.err       = 1'b0;
        if (r_state != c_IDLE) begin
            bus.gnt0 = ~r_owner;
            bus.gnt1 = r_owner;
        end
        if (r_state == c_RESP) begin
            bus.done0 = ~r_owner;
            bus.done1 = r_owner;
`ifdef ARB_TIMEOUT_EN
            bus.err   = r_tmo;
`endif
        end
        bus.mul_start = (r_state == c_ISSUE);
        bus.mul_a     = r_mul_a;
        bus.mul_b     = r_mul_b;
        bus.result    = r_result;
    end
endmodule
`default_nettype wire
